// File: rtl/full_dmrf_alu_pkg.sv
// Shared encodings for the datapath slice: ALUOp classes, R-type funct codes
// and the internal 4-bit ALU-control codes.
package full_dmrf_alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADD2  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

endpackage

// File: rtl/full_dmrf_alu_alu_ctrl_unit.sv
// Maps the ALUOp class and R-type funct field onto an internal ALU-control code.
module alu_ctrl_unit
  import full_dmrf_alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_e  ctrl
);

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_NOR: ctrl = ALU_NOR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   ctrl = ALU_ADD; // unknown funct codes fall back to add
        endcase
      end
      default:     ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/full_dmrf_alu.sv
// Single-cycle slice: 32x32 register file, ALU and word-addressed data memory.
// Reads and the memory port are combinational; all writes commit on posedge clk.
module full_dmrf_alu
  import full_dmrf_alu_pkg::*;
#(
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic [5:0]  FuncCode,
  input  logic [1:0]  ALUOp,
  input  logic [4:0]  Read1,
  input  logic [4:0]  Read2,
  input  logic [4:0]  WriteReg,
  output logic [31:0] ALUOut,
  output logic        Zero,
  output logic [31:0] MemData
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] a, b;
  logic [AW-1:0] addr;
  alu_ctrl_e   ctrl;

  alu_ctrl_unit u_ctrl (
    .alu_op (ALUOp),
    .funct  (FuncCode),
    .ctrl   (ctrl)
  );

  assign a = (Read1 == 5'd0) ? 32'd0 : regs[Read1];
  assign b = (Read2 == 5'd0) ? 32'd0 : regs[Read2];

  always_comb begin
    ALUOut = a + b;
    case (ctrl)
      ALU_SUB: ALUOut = a - b;
      ALU_AND: ALUOut = a & b;
      ALU_OR:  ALUOut = a | b;
      ALU_NOR: ALUOut = ~(a | b);
      ALU_SLT: ALUOut = {31'd0, $signed(a) < $signed(b)};
      default: ALUOut = a + b;
    endcase
  end

  assign Zero    = (ALUOut == 32'd0);
  // Byte address from the ALU; low two bits and upper bits are dropped.
  assign addr    = ALUOut[AW+1:2];
  assign MemData = dmem[addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (RegWrite && WriteReg != 5'd0) begin
      regs[WriteReg] <= ALUOut;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'd0;
    end else if (MemWrite) begin
      dmem[addr] <= b;
    end
  end

endmodule

// File: tb/tb_full_dmrf_alu.sv
// Directed-vector bench: stimulus pushes hand-computed results into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_full_dmrf_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemWrite = 1'b0, RegWrite = 1'b0;
  logic [5:0]  FuncCode = '0;
  logic [1:0]  ALUOp = '0;
  logic [4:0]  Read1 = '0, Read2 = '0, WriteReg = '0;
  logic [31:0] ALUOut, MemData;
  logic        Zero;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] mem;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  full_dmrf_alu dut (
    .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .FuncCode(FuncCode), .ALUOp(ALUOp), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .ALUOut(ALUOut), .Zero(Zero), .MemData(MemData)
  );

  always #5 clk = ~clk;

  task automatic apply(input string nm, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] op, input logic [5:0] fc, input logic rw,
                       input logic [4:0] wr, input logic mw, input logic [31:0] ea,
                       input logic ez, input logic [31:0] em);
    exp_t e;
    @(posedge clk);
    #1;
    Read1 = r1; Read2 = r2; ALUOp = op; FuncCode = fc;
    RegWrite = rw; WriteReg = wr; MemWrite = mw;
    e.name = nm; e.alu = ea; e.zero = ez; e.mem = em;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks += 3;
      if (ALUOut !== e.alu) begin
        n_fail++;
        $display("FAIL %s alu: got %08h want %08h", e.name, ALUOut, e.alu);
      end
      if (Zero !== e.zero) begin
        n_fail++;
        $display("FAIL %s zero: got %0b want %0b", e.name, Zero, e.zero);
      end
      if (MemData !== e.mem) begin
        n_fail++;
        $display("FAIL %s mem: got %08h want %08h", e.name, MemData, e.mem);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //     name        r1  r2  op     funct      rw wr  mw  alu           z  mem
    apply("rst_add",   3,  5,  2'b00, 6'b000000, 0, 0,  0, 32'd8,        0, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    apply("sub_zero",  5,  5,  2'b01, 6'b000000, 0, 0,  0, 32'd0,        1, 32'd0);
    apply("and",       12, 10, 2'b10, 6'b100100, 0, 0,  0, 32'd8,        0, 32'd0);
    apply("or",        12, 10, 2'b10, 6'b100101, 0, 0,  0, 32'd14,       0, 32'd0);
    apply("slt_f",     12, 10, 2'b10, 6'b101010, 0, 0,  0, 32'd0,        1, 32'd0);
    apply("funct0",    12, 10, 2'b10, 6'b000000, 0, 0,  0, 32'd22,       0, 32'd0);
    apply("rsub",      12, 10, 2'b10, 6'b100010, 0, 0,  0, 32'd2,        0, 32'd0);
    apply("nor",       12, 10, 2'b10, 6'b100111, 0, 0,  0, 32'hFFFFFFF1, 0, 32'd0);
    apply("op11",      12, 10, 2'b11, 6'b100010, 0, 0,  0, 32'd22,       0, 32'd0);
    apply("radd",      12, 10, 2'b10, 6'b100000, 0, 0,  0, 32'd22,       0, 32'd0);
    apply("wb_issue",  6,  9,  2'b00, 6'b000000, 1, 7,  0, 32'd15,       0, 32'd0);
    apply("wb_read",   7,  0,  2'b00, 6'b000000, 0, 0,  0, 32'd15,       0, 32'd0);
    apply("st_issue",  6,  9,  2'b00, 6'b000000, 0, 0,  1, 32'd15,       0, 32'd0);
    apply("st_read",   6,  9,  2'b00, 6'b000000, 0, 0,  0, 32'd15,       0, 32'd9);
    apply("both_iss",  1,  2,  2'b00, 6'b000000, 1, 1,  1, 32'd3,        0, 32'd0);
    apply("both_rd",   1,  0,  2'b00, 6'b000000, 0, 0,  0, 32'd3,        0, 32'd2);
    apply("neg_st",    0,  1,  2'b01, 6'b000000, 1, 8,  1, 32'hFFFFFFFD, 0, 32'd0);
    apply("wrap_rd",   8,  0,  2'b00, 6'b000000, 0, 0,  0, 32'hFFFFFFFD, 0, 32'd3);
    apply("slt_neg",   8,  2,  2'b10, 6'b101010, 0, 0,  0, 32'd1,        0, 32'd2);
    apply("slt_pos",   2,  8,  2'b10, 6'b101010, 0, 0,  0, 32'd0,        1, 32'd2);
    apply("r0_write",  3,  4,  2'b00, 6'b000000, 1, 0,  0, 32'd7,        0, 32'd0);
    apply("r0_read",   0,  0,  2'b00, 6'b000000, 0, 0,  0, 32'd0,        1, 32'd2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    apply("rst_regs",  7,  8,  2'b00, 6'b000000, 0, 0,  0, 32'd15,       0, 32'd0);
    apply("rst_mem",   1,  0,  2'b00, 6'b000000, 0, 0,  0, 32'd1,        0, 32'd0);
    apply("old_val",   7,  7,  2'b00, 6'b000000, 1, 7,  0, 32'd14,       0, 32'd0);
    apply("new_val",   7,  0,  2'b00, 6'b000000, 0, 0,  0, 32'd14,       0, 32'd0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results never checked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
